// File: rtl/ctrl_seq_pkg.sv
// Shared state codes, instruction-class codes and IR bit positions for the
// control-unit sequencer.
package ctrl_seq_pkg;

  localparam int STATE_CODE_W = 7;

  typedef enum logic [STATE_CODE_W-1:0] {
    S_RESET    = 7'd0,
    S_FADDR    = 7'd1,
    S_FREQ     = 7'd2,
    S_FWAIT    = 7'd3,
    S_DECODE   = 7'd4,
    S_DP_REG   = 7'd5,
    S_DP_IMM   = 7'd6,
    S_BR       = 7'd8,
    S_BR_FLUSH = 7'd9,
    S_BL_LINK  = 7'd10,
    S_LS_ADDR  = 7'd33,
    S_LS_REQ   = 7'd34,
    S_LS_WAIT  = 7'd35,
    S_LS_WB    = 7'd36,
    S_LD_REG   = 7'd43,
    S_UNDEF    = 7'd48,
    S_BUS_ERR  = 7'd63
  } state_e;

  // Instruction class, ir[27:25]
  localparam logic [2:0] CLS_DP_SHIFT = 3'b000;
  localparam logic [2:0] CLS_DP_IMM   = 3'b001;
  localparam logic [2:0] CLS_LS_IMM   = 3'b010;
  localparam logic [2:0] CLS_LS_REG   = 3'b011;
  localparam logic [2:0] CLS_BRANCH   = 3'b101;

  // Load/store control bits; bit 24 doubles as the link bit for branches
  localparam int BIT_P    = 24;
  localparam int BIT_LINK = 24;
  localparam int BIT_U    = 23;
  localparam int BIT_B    = 22;
  localparam int BIT_W    = 21;
  localparam int BIT_L    = 20;

endpackage

// File: rtl/ctrl_sequencer_moc_wait_timer.sv
// Memory-completion wait counter shared by the fetch and load/store wait
// states; flags a timeout on the last permitted waiting cycle.
module moc_wait_timer #(
  parameter int MOC_TIMEOUT = 16,
  parameter bit TIMEOUT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic moc,
  output logic timeout
);

  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Held at zero outside the wait states, so every entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting || moc) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = TIMEOUT_EN && waiting && (wait_cnt == CNT_TO);

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control-unit sequencer: decodes the latched instruction class
// into a state sequence that drives the control-signal ROM.
//
// state    | meaning
// RESET    | post-reset idle       FADDR/FREQ/FWAIT | fetch addr, request, wait moc
// DECODE   | class/cond decode     DP_REG/DP_IMM    | data-processing writeback
// BL_LINK  | write link register   BR/BR_FLUSH      | load PC, flush pipeline
// LS_ADDR  | address calc          LS_REQ/LS_WAIT   | data request, wait moc
// LD_REG   | load result write     LS_WB            | base writeback
// UNDEF    | undefined trap        BUS_ERR          | moc timeout, wait err_ack
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int STATE_W     = 7,
  parameter int IR_W        = 32,
  parameter int MOC_TIMEOUT = 16,
  parameter bit TIMEOUT_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               moc,
  input  logic               cond,
  input  logic [IR_W-1:0]    ir,
  input  logic               err_ack,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               mem_rw,
  output logic               mem_byte,
  output logic               reg_wr,
  output logic               pc_ld,
  output logic               bus_err,
  output logic               undef
);

  state_e       state_q, state_d;
  logic [27:20] ir_q;
  logic         bus_err_q;
  logic         waiting, timeout, wb;
  logic         fetch_st, ls_st;
  logic         unused_ir;

  // Only the class and load/store control field is needed downstream.
  assign unused_ir = ^ir;

  assign waiting = (state_q == S_FWAIT) || (state_q == S_LS_WAIT);
  assign wb      = !ir_q[BIT_P] || ir_q[BIT_W];

  moc_wait_timer #(
    .MOC_TIMEOUT (MOC_TIMEOUT),
    .TIMEOUT_EN  (TIMEOUT_EN)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .moc     (moc),
    .timeout (timeout)
  );

  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:  state_d = S_FADDR;
      S_FADDR:  state_d = S_FREQ;
      S_FREQ:   state_d = S_FWAIT;
      S_FWAIT: begin
        if (moc)          state_d = S_DECODE;
        else if (timeout) state_d = S_BUS_ERR;
        else              state_d = S_FWAIT;
      end
      S_DECODE: begin
        if (!cond) begin
          state_d = S_FADDR;
        end else begin
          case (ir_q[27:25])
            CLS_DP_SHIFT:           state_d = S_DP_REG;
            CLS_DP_IMM:             state_d = S_DP_IMM;
            CLS_BRANCH:             state_d = ir_q[BIT_LINK] ? S_BL_LINK : S_BR;
            CLS_LS_IMM, CLS_LS_REG: state_d = S_LS_ADDR;
            default:                state_d = S_UNDEF;
          endcase
        end
      end
      S_DP_REG, S_DP_IMM, S_UNDEF, S_LS_WB, S_BR_FLUSH: state_d = S_FADDR;
      S_BL_LINK: state_d = S_BR;
      S_BR:      state_d = S_BR_FLUSH;
      S_LS_ADDR: state_d = S_LS_REQ;
      S_LS_REQ:  state_d = S_LS_WAIT;
      S_LS_WAIT: begin
        // moc in the timeout cycle still completes the access normally
        if (moc) begin
          if (ir_q[BIT_L]) state_d = S_LD_REG;
          else             state_d = wb ? S_LS_WB : S_FADDR;
        end else if (timeout) begin
          state_d = S_BUS_ERR;
        end else begin
          state_d = S_LS_WAIT;
        end
      end
      S_LD_REG:  state_d = wb ? S_LS_WB : S_FADDR;
      S_BUS_ERR: state_d = err_ack ? S_FADDR : S_BUS_ERR;
      default:   state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      ir_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FWAIT && moc) ir_q <= ir[27:20];
      if (state_d == S_BUS_ERR)                    bus_err_q <= 1'b1;
      else if (state_q == S_BUS_ERR && err_ack)    bus_err_q <= 1'b0;
    end
  end

  assign fetch_st = (state_q == S_FADDR) || (state_q == S_FREQ) || (state_q == S_FWAIT);
  assign ls_st    = (state_q == S_LS_ADDR) || (state_q == S_LS_REQ) || (state_q == S_LS_WAIT) ||
                    (state_q == S_LS_WB)   || (state_q == S_LD_REG);

  assign state    = STATE_W'(state_q);
  assign mem_req  = (state_q == S_FREQ) || (state_q == S_FWAIT) ||
                    (state_q == S_LS_REQ) || (state_q == S_LS_WAIT);
  assign mem_rw   = fetch_st || (ls_st && ir_q[BIT_L]);
  assign mem_byte = ls_st && ir_q[BIT_B];
  assign reg_wr   = (state_q == S_DP_REG) || (state_q == S_DP_IMM) || (state_q == S_BL_LINK) ||
                    (state_q == S_LD_REG) || (state_q == S_LS_WB);
  assign pc_ld    = (state_q == S_BR);
  assign undef    = (state_q == S_UNDEF);
  assign bus_err  = bus_err_q;

endmodule
